bastim_int_ctrl: RTL
====================

BASTIM_INT_CTRL -- requirements
Module: bastim_int_ctrl

Interface
REQ-001 Parameter: CNT_W, default 8, width of each per-channel overrun counter.
REQ-002 ch_clk  input  1  single block clock, all state on rising edge.
REQ-003 ch_rstn  input  1  asynchronous, active-low reset.
REQ-004 int_status_ch_reload  input  4  per-channel timer reload event, one bit per basic-timer channel, synchronous to ch_clk.
REQ-005 int_enable  input  4  per-channel interrupt mask, 1 = channel contributes to irq.
REQ-006 int_clear  input  4  per-channel write-1-to-clear strobe, one cycle wide, from register bus.
REQ-007 int_pending  output  4  per-channel sticky pending flag.
REQ-008 int_overrun  output  4  per-channel sticky flag, event lost while pending.
REQ-009 int_ovr_cnt  output  4*CNT_W  per-channel saturating lost-event count, channel i at bits [i*CNT_W +: CNT_W].
REQ-010 irq  output  1  registered combined interrupt request to the CPU.

Function
REQ-011 Event detect: event[i] = int_status_ch_reload[i] & ~prev[i], where prev is the input registered each cycle; a level held N cycles produces exactly one event.
REQ-012 Per-channel FSM states: IDLE (pending=0), PEND (pending=1, overrun=0), OVR (pending=1, overrun=1).
REQ-013 IDLE -> PEND on event.
REQ-014 PEND -> OVR on event without int_clear[i]; counter increments by 1.
REQ-015 OVR -> OVR on event without int_clear[i]; counter increments by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-016 PEND or OVR -> IDLE on int_clear[i] without event; overrun and counter cleared to 0 in the same edge.
REQ-017 Simultaneous int_clear[i] and event in PEND or OVR: set wins -> PEND; overrun and counter cleared; no increment.
REQ-018 int_clear[i] in IDLE has no effect; event plus int_clear[i] in IDLE -> PEND.
REQ-019 Latency: event sampled at edge k -> int_pending[i]=1 after edge k; irq=1 after edge k+1.
REQ-020 irq register next value = |(int_pending & int_enable); mask or clear changes reach irq one edge later.
REQ-021 int_enable masks only irq; pending, overrun and counters update regardless of mask.
REQ-022 Channels fully independent; no cross-channel priority.
REQ-023 All outputs driven directly from flops, no combinational input-to-output path.

Reset
REQ-024 ch_rstn low asynchronously forces prev, int_pending, int_overrun, int_ovr_cnt, irq to 0 and all FSMs to IDLE.
REQ-025 Input held high across reset release produces one event on the first edge after release (prev reset to 0).
REQ-026 Reset asserted mid-operation (any state, saturated counter) returns all outputs to 0 immediately, without waiting for a clock edge.

Verification
REQ-027 ch0 pulse 1 cycle, int_enable=4'b0001 -> int_pending=4'b0001 after edge k, irq=1 after edge k+1; int_clear=4'b0001 -> pending 0, irq 0 one edge later.
REQ-028 ch2 held high 10 cycles -> single event; int_pending[2]=1, int_overrun[2]=0, count 0.
REQ-029 ch1 three pulses, no clear -> int_overrun[1]=1, cnt[1]=2; 300 pulses -> cnt[1]=255 (saturated).
REQ-030 ch3 pending, event and int_clear[3] same cycle -> int_pending[3]=1, int_overrun[3]=0, cnt[3]=0.
REQ-031 All channels pending, int_enable=0 -> irq=0; int_enable=4'b1000 -> irq=1 one edge later.
REQ-032 ch_rstn pulsed low between edges while in OVR with cnt=255 -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/bastim_int_ctrl.sv
// Interrupt controller for four basic-timer channels: edge detect, sticky
// pending/overrun per channel, saturating lost-event counters, and a registered irq.
module bastim_int_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic                 ch_clk,
    input  logic                 ch_rstn,
    input  logic [3:0]           int_status_ch_reload,
    input  logic [3:0]           int_enable,
    input  logic [3:0]           int_clear,
    output logic [3:0]           int_pending,
    output logic [3:0]           int_overrun,
    output logic [4*CNT_W-1:0]   int_ovr_cnt,
    output logic                 irq
);

    // Bit 0 of the encoding is the pending flag and bit 1 the overrun flag.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_OVR  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q [4];
    state_e           state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [3:0]       prev_q;
    logic [3:0]       prev_d;
    logic [3:0]       evt;
    logic             irq_q;
    logic             irq_d;

    always_ff @(posedge ch_clk or negedge ch_rstn) begin
        if (!ch_rstn) begin
            prev_q <= '0;
            irq_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            prev_q <= prev_d;
            irq_q  <= irq_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        prev_d = int_status_ch_reload;
        evt    = int_status_ch_reload & ~prev_q;
        irq_d  = |(int_pending & int_enable);
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (evt[i]) begin
                        state_d[i] = ST_PEND;
                    end
                end
                ST_PEND, ST_OVR: begin
                    // A new event beats a simultaneous clear and restarts the channel.
                    if (evt[i] && int_clear[i]) begin
                        state_d[i] = ST_PEND;
                        cnt_d[i]   = '0;
                    end else if (evt[i]) begin
                        state_d[i] = ST_OVR;
                        if (cnt_q[i] != CNT_MAX) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end else if (int_clear[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign int_pending[g]                  = state_q[g][0];
        assign int_overrun[g]                  = state_q[g][1];
        assign int_ovr_cnt[g*CNT_W +: CNT_W]   = cnt_q[g];
    end

    assign irq = irq_q;

endmodule
